// File: rtl/clock_adjust_ctrl.sv
// Key-driven adjust controller: steps the blink field normal -> minutes -> hours,
// applies BCD increments to the running time (via a load strobe) or to the alarm registers.
module clock_adjust_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sw17,
  input  logic [3:0] min_l,
  input  logic [3:0] min_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] hour_h,
  output logic [1:0] adjust,
  output logic       set_en,
  output logic [3:0] set_min_l,
  output logic [3:0] set_min_h,
  output logic [3:0] set_hour_l,
  output logic [3:0] set_hour_h,
  output logic [3:0] alarm_min_l,
  output logic [3:0] alarm_min_h,
  output logic [3:0] alarm_hour_l,
  output logic [3:0] alarm_hour_h
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADJ_MIN  = 2'd1,
    ADJ_HOUR = 2'd2
  } state_e;

  state_e        state_q;
  logic [1:0]    adjust_q;
  logic [TW-1:0] tcnt_q;
  logic          set_en_q;
  logic [15:0]   set_q;    // {hour_h, hour_l, min_h, min_l}
  logic [15:0]   alarm_q;  // {hour_h, hour_l, min_h, min_l}

  logic [15:0] src_time;
  logic [7:0]  min_src, hour_src, min_inc, hour_inc;
  logic        timeout;

  function automatic logic [7:0] inc_min(input logic [7:0] v);
    logic [3:0] h, l;
    h = v[7:4];
    l = v[3:0];
    if (l > 4'd9 || h > 4'd5) return 8'h00;
    if (l < 4'd9)             return {h, l + 4'd1};
    if (h < 4'd5)             return {h + 4'd1, 4'd0};
    return 8'h00;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [3:0] h, l;
    h = v[7:4];
    l = v[3:0];
    if ((h == 4'd2 && l >= 4'd3) || h > 4'd2) return 8'h00;
    if (l >= 4'd9)                            return {h + 4'd1, 4'd0};
    return {h, l + 4'd1};
  endfunction

  // The time counter only shows a load two cycles later, so a load issued last
  // cycle is the true current time for a back-to-back increment.
  always_comb begin
    src_time = set_en_q ? set_q : {hour_h, hour_l, min_h, min_l};
    min_src  = sw17 ? alarm_q[7:0]  : src_time[7:0];
    hour_src = sw17 ? alarm_q[15:8] : src_time[15:8];
    min_inc  = inc_min(min_src);
    hour_inc = inc_hour(hour_src);
    timeout  = (tcnt_q == TLAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      adjust_q <= 2'd0;
      tcnt_q   <= '0;
      set_en_q <= 1'b0;
      set_q    <= '0;
      alarm_q  <= '0;
    end else begin
      set_en_q <= 1'b0;
      case (state_q)
        ADJ_MIN, ADJ_HOUR: begin
          if (key_mode) begin
            tcnt_q   <= '0;
            state_q  <= (state_q == ADJ_MIN) ? ADJ_HOUR : IDLE;
            adjust_q <= (state_q == ADJ_MIN) ? 2'd2 : 2'd0;
          end else if (key_inc) begin
            tcnt_q <= '0;
            if (state_q == ADJ_MIN) begin
              if (sw17) alarm_q[7:0] <= min_inc;
              else begin
                set_en_q <= 1'b1;
                set_q    <= {src_time[15:8], min_inc};
              end
            end else begin
              if (sw17) alarm_q[15:8] <= hour_inc;
              else begin
                set_en_q <= 1'b1;
                set_q    <= {hour_inc, src_time[7:0]};
              end
            end
          end else if (timeout) begin
            tcnt_q   <= '0;
            state_q  <= IDLE;
            adjust_q <= 2'd0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        default: begin
          tcnt_q <= '0;
          if (key_mode) begin
            state_q  <= ADJ_MIN;
            adjust_q <= 2'd1;
          end else begin
            state_q  <= IDLE;
            adjust_q <= 2'd0;
          end
        end
      endcase
    end
  end

  assign adjust       = adjust_q;
  assign set_en       = set_en_q;
  assign set_min_l    = set_q[3:0];
  assign set_min_h    = set_q[7:4];
  assign set_hour_l   = set_q[11:8];
  assign set_hour_h   = set_q[15:12];
  assign alarm_min_l  = alarm_q[3:0];
  assign alarm_min_h  = alarm_q[7:4];
  assign alarm_hour_l = alarm_q[11:8];
  assign alarm_hour_h = alarm_q[15:12];

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Directed bench for clock_adjust_ctrl with a short timeout (16 cycles).
module tb_clock_adjust_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic       sw17 = 1'b0;
  logic [3:0] min_l = '0, min_h = '0, hour_l = '0, hour_h = '0;
  logic [1:0] adjust;
  logic       set_en;
  logic [3:0] set_min_l, set_min_h, set_hour_l, set_hour_h;
  logic [3:0] alarm_min_l, alarm_min_h, alarm_hour_l, alarm_hour_h;

  int pass_cnt = 0;
  int total_cnt = 0;
  int se_cnt;

  clock_adjust_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc), .sw17(sw17),
    .min_l(min_l), .min_h(min_h), .hour_l(hour_l), .hour_h(hour_h),
    .adjust(adjust), .set_en(set_en),
    .set_min_l(set_min_l), .set_min_h(set_min_h),
    .set_hour_l(set_hour_l), .set_hour_h(set_hour_h),
    .alarm_min_l(alarm_min_l), .alarm_min_h(alarm_min_h),
    .alarm_hour_l(alarm_hour_l), .alarm_hour_h(alarm_hour_h)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pulse_mode();
    key_mode = 1'b1;
    tick();
    key_mode = 1'b0;
  endtask

  task automatic pulse_inc();
    key_inc = 1'b1;
    tick();
    key_inc = 1'b0;
  endtask

  function automatic logic [15:0] set_v();
    return {set_hour_h, set_hour_l, set_min_h, set_min_l};
  endfunction

  function automatic logic [15:0] alarm_v();
    return {alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l};
  endfunction

  initial begin
    // Reset state
    #22;
    check("rst_adjust", 16'(adjust), 16'd0);
    check("rst_set_en", 16'(set_en), 16'd0);
    check("rst_set", set_v(), 16'h0000);
    check("rst_alarm", alarm_v(), 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Mode cycling
    pulse_mode(); check("mode_1", 16'(adjust), 16'd1);
    pulse_mode(); check("mode_2", 16'(adjust), 16'd2);
    pulse_mode(); check("mode_0", 16'(adjust), 16'd0);

    // Time target minutes 12:59 -> 12:00
    {hour_h, hour_l, min_h, min_l} = 16'h1259;
    sw17 = 1'b0;
    pulse_mode();
    pulse_inc();
    check("tmin_set_en", 16'(set_en), 16'd1);
    check("tmin_set", set_v(), 16'h1200);
    tick();
    check("tmin_set_en_low", 16'(set_en), 16'd0);
    check("tmin_set_hold", set_v(), 16'h1200);
    check("tmin_alarm_untouched", alarm_v(), 16'h0000);

    // Alarm target: back-to-back minute increments to 00:45
    sw17 = 1'b1;
    se_cnt = 0;
    key_inc = 1'b1;
    repeat (45) begin
      tick();
      if (set_en) se_cnt++;
    end
    key_inc = 1'b0;
    check("amin_45", alarm_v(), 16'h0045);
    pulse_mode();
    check("amode_hour", 16'(adjust), 16'd2);
    key_inc = 1'b1;
    repeat (23) begin
      tick();
      if (set_en) se_cnt++;
    end
    key_inc = 1'b0;
    check("ahour_23", alarm_v(), 16'h2345);
    pulse_inc();
    if (set_en) se_cnt++;
    check("ahour_wrap", alarm_v(), 16'h0045);
    key_inc = 1'b1;
    repeat (2) begin
      tick();
      if (set_en) se_cnt++;
    end
    key_inc = 1'b0;
    check("ahour_b2b", alarm_v(), 16'h0245);
    check("alarm_no_set_en", 16'(se_cnt), 16'd0);
    check("alarm_set_untouched", set_v(), 16'h1200);

    // Time target back-to-back from 10:08, counter lagging
    sw17 = 1'b0;
    pulse_mode(); check("back_idle", 16'(adjust), 16'd0);
    pulse_mode(); check("back_min", 16'(adjust), 16'd1);
    {hour_h, hour_l, min_h, min_l} = 16'h1008;
    key_inc = 1'b1;
    tick();
    check("b2b_1_en", 16'(set_en), 16'd1);
    check("b2b_1_set", set_v(), 16'h1009);
    tick();
    key_inc = 1'b0;
    check("b2b_2_en", 16'(set_en), 16'd1);
    check("b2b_2_set", set_v(), 16'h1010);
    tick();
    check("b2b_end_en", 16'(set_en), 16'd0);

    // Simultaneous mode + inc in ADJ_MIN
    key_mode = 1'b1;
    key_inc = 1'b1;
    tick();
    key_mode = 1'b0;
    key_inc = 1'b0;
    check("simul_adjust", 16'(adjust), 16'd2);
    check("simul_set_en", 16'(set_en), 16'd0);
    check("simul_set", set_v(), 16'h1010);
    pulse_mode();
    check("simul_idle", 16'(adjust), 16'd0);

    // Timeout: no keys, return at K+17
    pulse_mode();
    repeat (15) tick();
    check("to_k16", 16'(adjust), 16'd1);
    tick();
    check("to_k17", 16'(adjust), 16'd0);

    // Timeout restart: key_inc in the timeout cycle is honoured
    pulse_mode();
    repeat (15) tick();
    key_inc = 1'b1;
    tick();
    key_inc = 1'b0;
    check("tor_key_wins", 16'(adjust), 16'd1);
    check("tor_key_set_en", 16'(set_en), 16'd1);
    repeat (15) tick();
    check("tor_k16", 16'(adjust), 16'd1);
    tick();
    check("tor_k17", 16'(adjust), 16'd0);

    // key_inc in IDLE ignored
    pulse_inc();
    check("idle_inc_set_en", 16'(set_en), 16'd0);
    check("idle_inc_adjust", 16'(adjust), 16'd0);
    check("idle_inc_alarm", alarm_v(), 16'h0245);

    // Asynchronous reset mid-adjust
    pulse_mode();
    pulse_mode();
    check("pre_rst_adjust", 16'(adjust), 16'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_adjust", 16'(adjust), 16'd0);
    check("mid_rst_alarm", alarm_v(), 16'h0000);
    check("mid_rst_set", set_v(), 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clock_adjust_ctrl.md
# clock_adjust_ctrl

Key-driven adjust controller for the alarm clock. It sequences the display's `adjust` blink field through normal → minutes → hours, and applies BCD increments on key presses. Edits go either to the running time counter, through a one-cycle load strobe, or to the alarm registers, which this block owns. It sits between the debounced key inputs and the time counter / 7-segment display blocks.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 500_000_000: number of key-idle cycles in an adjust state before the block returns to normal (10 s at 50 MHz).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `key_mode`  in  1  debounced single-cycle pulse; advances the adjust state
- `key_inc`  in  1  debounced single-cycle pulse; increments the selected field
- `sw17`  in  1  edit target, sampled live: 0 = time, 1 = alarm
- `min_l`, `min_h`, `hour_l`, `hour_h`  in  4 each  current time in BCD, from the time counter
- `adjust`  out  2  0 = normal, 1 = minutes blinking, 2 = hours blinking; 3 is never driven
- `set_en`  out  1  one-cycle time-load strobe
- `set_min_l`, `set_min_h`, `set_hour_l`, `set_hour_h`  out  4 each  time-load values
- `alarm_min_l`, `alarm_min_h`, `alarm_hour_l`, `alarm_hour_h`  out  4 each  alarm registers

## Operation
- FSM states: IDLE (`adjust`=0), ADJ_MIN (`adjust`=1), ADJ_HOUR (`adjust`=2). `adjust` is a registered decode of the state.
- `key_mode` transitions: IDLE→ADJ_MIN, ADJ_MIN→ADJ_HOUR, ADJ_HOUR→IDLE.
- `key_inc` in IDLE is ignored.
- `key_inc` in ADJ_MIN:
  - Source value is the alarm minutes if `sw17`=1, otherwise the time minutes.
  - Minutes increment as BCD 00→59→00, with no carry into hours.
- `key_inc` in ADJ_HOUR: hours increment as BCD 00→23→00, with no carry.
- Minute increment rule:
  - If l<9: l+1.
  - Else l=0, and h+1 if h<5, else h=0.
  - Out-of-range inputs (l>9 or h>5) wrap to 00.
- Hour increment rule:
  - If h==2 and l>=3, or h>2: result is 00.
  - Else if l>=9: l=0, h+1.
  - Else l+1.
- Time target (`sw17`=0):
  - `set_en` pulses for one cycle.
  - The `set_*` outputs carry all four digits: the incremented field plus a pass-through copy of the other field's inputs.
  - Consumer contract: on `set_en`, load all four digits and clear seconds.
  - `set_*` hold their last value while `set_en` is low.
- Alarm target (`sw17`=1): only the selected alarm field updates. `set_en` stays low.
- Idle timeout:
  - Counter `tcnt` is held at 0 in IDLE.
  - In ADJ states it increments every cycle, and clears on any `key_mode` or `key_inc` pulse.
  - When `tcnt`==TIMEOUT_CYC-1, the state goes to IDLE. Edits already applied are kept.
- Simultaneous events:
  - `key_mode` and `key_inc` in the same cycle: `key_mode` wins and `key_inc` is dropped.
  - A key pulse in the timeout cycle wins: the key action is taken and `tcnt` clears.
- `sw17` toggling mid-adjust does not change state. Each increment uses `sw17` as sampled in that cycle.

## Timing
- Reset values: state IDLE, `adjust`=0, `set_en`=0, all `set_*`=0, all `alarm_*`=0 (00:00), `tcnt`=0.
- Reset asserted mid-adjust: the block returns to IDLE immediately and the alarm registers clear.
- `key_mode` at cycle N: `adjust` holds the new value from N+1.
- `key_inc` at cycle N:
  - Time target: `set_en`=1 and `set_*` valid at N+1 only. Values are computed from `min_*`/`hour_*` sampled at N.
  - Alarm target: the new `alarm_*` value is visible at N+1.
- Back-to-back `key_inc` at N and N+1: the second increment must use the value committed by the first.
  - Alarm target: reads the internal register.
  - Time target: the time counter reflects the load at N+2, so the block keeps a shadow of the last `set_*` and uses it when `set_en` was high in the previous cycle.
- Timeout: with the last key at cycle K, `adjust` returns to 0 at K+TIMEOUT_CYC+1.

## Test plan
- Reset → all outputs 0; three `key_mode` pulses → `adjust` goes 1, 2, 0, each one cycle after its pulse.
- Time target, ADJ_MIN, time 12:59, `key_inc` → next cycle `set_en`=1 with `set_*`=1,2,0,0 (12:00); `set_en` low the following cycle.
- Alarm target, ADJ_HOUR, alarm 23:45, `key_inc` → alarm 00:45, `set_en` never asserts; two more back-to-back `key_inc` → 02:45.
- Time target, two back-to-back `key_inc` in ADJ_MIN from 10:08 with the counter lagging one cycle → loads 10:09, then 10:10.
- With TIMEOUT_CYC=16, enter ADJ_MIN and send no keys → `adjust`=0 after exactly 17 cycles; a `key_inc` at cycle 15 restarts the count.
- `key_mode` and `key_inc` in the same cycle while in ADJ_MIN → state goes to ADJ_HOUR, no increment, no `set_en`.
